// File: rtl/vram_pkg.sv
// Shared VRAM geometry and clear-engine state encoding for the low-res RGB path.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 15;
    localparam int unsigned VRAM_DEPTH  = 19200;
    localparam int unsigned PIX_W       = 3;
    localparam int unsigned LOWRES_H    = 160;
    localparam int unsigned LOWRES_V    = 120;

    // Clear engine is either parked or sweeping the frame.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt_c
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    int unsigned      sum;
    int unsigned      nxt;
    logic             found;

    // Search from the pointer, wrapping modulo N; first requester found wins.
    always_comb begin
        gnt_c   = '0;
        ptr_nxt = ptr;
        sum     = 0;
        nxt     = 0;
        found   = 1'b0;
        if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                sum = 32'(ptr) + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                if (!found && req[PTR_W'(sum)]) begin
                    found              = 1'b1;
                    gnt_c[PTR_W'(sum)] = 1'b1;
                    nxt                = sum + 1;
                    if (nxt >= N) begin
                        nxt = nxt - N;
                    end
                    ptr_nxt = PTR_W'(nxt);
                end
            end
        end
    end

    // Pointer register; only moves on a real grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM owner: scan-out reads first, then frame clear, then round-robin writers.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned DEPTH  = VRAM_DEPTH,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_req,
    input  logic [ADDR_W-1:0]        scan_addr,
    output logic [DATA_W-1:0]        scan_data,
    output logic                     scan_valid,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_gnt,
    input  logic                     clear_start,
    input  logic [DATA_W-1:0]        clear_data,
    output logic                     clear_busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e          state;
    clr_state_e          state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_nxt;
    logic [DATA_W-1:0]   color;
    logic [DATA_W-1:0]   color_nxt;

    logic                mem_en_nxt;
    logic                mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;

    logic                arb_en;
    logic [NUM_WR-1:0]   gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Writers compete only when scan-out and the clear engine leave the port free;
    // grants are also held off during reset so no writer sees a phantom transfer.
    assign arb_en = !reset && !scan_req && (state == ST_IDLE);

    rr_arbiter #(
        .N (NUM_WR)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (wr_req),
        .gnt_c (gnt)
    );

    assign wr_gnt = gnt;

    // Pick the granted writer's address/data slice.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (gnt[i]) begin
                sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
                sel_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next memory command: scan > clear > writers > idle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        color_nxt     = color;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;

        if (scan_req) begin
            mem_en_nxt   = 1'b1;
            mem_addr_nxt = scan_addr;
        end else if (state == ST_CLEAR) begin
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = cnt;
            mem_wdata_nxt = color;
            if (cnt == LAST_ADDR) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + ADDR_W'(1);
            end
        end else if (|gnt) begin
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = sel_addr;
            mem_wdata_nxt = sel_data;
        end

        // A start pulse only counts from IDLE; a running fill is never restarted.
        if ((state == ST_IDLE) && clear_start) begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
            color_nxt = clear_data;
        end
    end

    // State, clear counter, memory command and read-return strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            color      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            clear_busy <= 1'b0;
            scan_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            color      <= color_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            clear_busy <= (state_nxt == ST_CLEAR);
            scan_valid <= mem_en && !mem_we;
        end
    end

    // VRAM returns read data the cycle after the read command, which is when
    // scan_valid rises; the data is passed straight through and zeroed otherwise.
    assign scan_data = scan_valid ? mem_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port video RAM (VRAM) that backs the 3-bit RGB display path.
- Shares the VRAM between three requesters:
  - the scan-out fetcher (hard real-time, absolute priority),
  - a built-in frame-clear engine,
  - NUM_WR game-logic writers, arbitrated round-robin.
- Runs in the 25 MHz pixel clock domain beside the hsync/vsync generator.

Parameters:
- ADDR_W, 15, VRAM word address width.
- DATA_W, 3, pixel width (one RGB bit each: bit0 R, bit1 G, bit2 B).
- DEPTH, 19200, VRAM words (160x120 low-res frame).
- NUM_WR, 2, number of writer ports.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-high.
- scan_req  in  1  scan-out read request; always serviced.
- scan_addr  in  ADDR_W  scan-out read address.
- scan_data  out  DATA_W  read data returned to scan-out.
- scan_valid  out  1  scan_data valid strobe.
- wr_req  in  NUM_WR  per-writer write request.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses; writer i uses slice i.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- wr_gnt  out  NUM_WR  one-hot grant; a write transfers when wr_req[i] and wr_gnt[i] are both high.
- clear_start  in  1  one-cycle pulse that starts a full-frame fill.
- clear_data  in  DATA_W  fill colour, sampled on clear_start.
- clear_busy  out  1  high while the clear engine runs.
- mem_en  out  1  VRAM enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, 1-cycle latency after mem_en with mem_we=0.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - On reset: all outputs 0, round-robin pointer 0, FSM in IDLE, clear counter 0, latched clear colour 0.
  - Reset mid-clear aborts the fill; no further mem writes are issued.
- Per-cycle priority, evaluated in cycle t:
  1. scan_req.
  2. Clear engine, when in CLEAR.
  3. Writers, round-robin.
  4. No access.
- wr_gnt is combinational in cycle t:
  - At most one bit set.
  - All zero when scan_req is high or the FSM is in CLEAR.
  - Only bits with wr_req set can be granted.
- Round-robin:
  - Search starts at pointer p and wraps modulo NUM_WR.
  - After writer k is granted, p becomes (k+1) mod NUM_WR.
  - p is unchanged on cycles with no writer grant.
- mem_* outputs are registered. The winner of cycle t drives mem_en/mem_we/mem_addr/mem_wdata in cycle t+1.
  - Scan read: mem_we=0.
  - Clear or writer access: mem_we=1.
  - No access: mem_en=0.
- Scan read latency: mem_rdata is captured at t+2, so scan_data/scan_valid assert in cycle t+2 (2 cycles after scan_req). scan_valid is high for exactly one cycle per request.
- Back-to-back scan_req is allowed every cycle; the read pipeline is fully pipelined.
- FSM states:
  - IDLE:
    - clear_start sets clear counter to 0, latches clear_data, and moves to CLEAR next cycle.
    - A writer granted in the same cycle as clear_start still completes.
  - CLEAR:
    - clear_busy=1.
    - On each cycle without scan_req: issue a write of the latched colour at the counter address, then increment the counter.
    - When the write to address DEPTH-1 is issued, return to IDLE; clear_busy drops in the next cycle.
    - clear_start while in CLEAR is ignored; the fill is not restarted.
- The counter is ADDR_W bits and never exceeds DEPTH-1.
- Writers with wr_req held and no grant must hold addr/data stable; the arbiter does not buffer writes.

Decomposition:
- Shared package vram_pkg holds:
  - VRAM_ADDR_W=15, VRAM_DEPTH=19200, PIX_W=3, LOWRES_H=160, LOWRES_V=120.
  - FSM state encoding (ST_IDLE, ST_CLEAR).
- One sub-module, rr_arbiter (NUM_WR requests, enable input, one-hot grant, internal pointer). It is instantiated once, with enable = !scan_req && state==ST_IDLE.

Test Plan:
- Reset: hold reset 3 cycles with wr_req=2'b11 -> wr_gnt=0, mem_en=0, clear_busy=0, scan_valid=0 throughout.
- Scan priority: scan_req=1 with scan_addr=100 while wr_req=2'b01 -> wr_gnt=0 and mem_addr=100, mem_we=0 at t+1; preloaded word 3'b101 appears on scan_data with scan_valid at t+2.
- Round-robin: wr_req=2'b11 held for 4 cycles, no scan -> grants 01,10,01,10; mem_addr alternates between wr_addr slices; after a lone wr_req=2'b10, the next contested cycle grants 01.
- Clear with scan interleave: DEPTH=16 build, clear_start with clear_data=3'b010, scan_req on every 3rd cycle -> exactly 16 writes of 3'b010 to addresses 0..15 in order; no write coincides with a scan read; clear_busy falls the cycle after the address-15 write; wr_gnt=0 throughout.
- Simultaneous events: clear_start in the same cycle as an unblocked wr_req=2'b01 -> writer write issued; clear begins next cycle; a second clear_start mid-fill does not reset the counter.
- Reset mid-clear: assert reset at counter=7 -> no mem write in the following cycles; clear_busy=0 after reset; a new clear_start begins at address 0.
